// File: rtl/pwrmgr_pkg.sv
// Shared types and constants for the power manager reset arbitration slice.
package pwrmgr_pkg;

    localparam int NumRstReqs = 2;
    localparam int EscIdx     = NumRstReqs;

    typedef logic [NumRstReqs:0] rst_src_t;

    typedef enum logic [1:0] {
        Idle    = 2'b00,
        ReqRst  = 2'b01,
        Hold    = 2'b10,
        Release = 2'b11
    } rst_arb_state_e;

endpackage

// File: rtl/pwrmgr_rst_prio_enc.sv
// Fixed-priority one-hot encoder: MSB (escalation) wins outright, otherwise
// the lowest set bit among the remaining sources. All-zero input gives zero.
module pwrmgr_rst_prio_enc #(
    parameter int Width = 3
) (
    input  logic [Width-1:0] req,
    output logic [Width-1:0] gnt
);

    logic [Width-2:0] low_s;
    logic [Width-2:0] low_gnt_s;

    assign low_s     = req[Width-2:0];
    // Two's-complement trick isolates the lowest set bit.
    assign low_gnt_s = low_s & (~low_s + (Width-1)'(1));
    assign gnt       = req[Width-1] ? {1'b1, {(Width-1){1'b0}}}
                                    : {1'b0, low_gnt_s};

endmodule

// File: rtl/pwrmgr_rst_arb.sv
// Reset request arbiter: latches peripheral/escalation reset requests into
// sticky pending bits and sequences one reset at a time to rstmgr through a
// four-phase req/ack handshake, recording the granted cause for software.
module pwrmgr_rst_arb
    import pwrmgr_pkg::*;
#(
    parameter int NumReqs    = NumRstReqs,
    parameter int HoldCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumReqs-1:0] req_i,
    input  logic [NumReqs-1:0] en_i,
    input  logic               esc_req_i,
    input  logic               clr_i,
    output logic               rst_req_o,
    input  logic               rst_ack_i,
    output logic [NumReqs:0]   pending_o,
    output logic [NumReqs:0]   cause_o,
    output logic               cause_valid_o,
    output logic               busy_o
);

    localparam logic [NumReqs:0] SrcZero  = {(NumReqs+1){1'b0}};
    localparam logic [7:0]       HoldLoad = 8'(HoldCycles - 1);

    rst_arb_state_e   state_r;
    logic [NumReqs:0] pending_r;
    logic [NumReqs:0] grant_r;
    logic [NumReqs:0] cause_r;
    logic             cause_valid_r;
    logic             rst_req_r;
    logic             busy_r;
    logic [7:0]       cnt_r;

    logic [NumReqs:0] set_s;
    logic [NumReqs:0] drop_s;
    logic [NumReqs:0] clr_grant_s;
    logic [NumReqs:0] gnt_s;

    // Escalation is always enabled; peripherals only when software allows.
    assign set_s  = {esc_req_i, req_i & en_i};
    // A disabled source loses its queued request unless it is being serviced.
    assign drop_s = {1'b0, ~en_i} & ~grant_r;

    // Retire the granted bit in the cycle the handshake completes.
    always_comb begin
        clr_grant_s = SrcZero;
        if ((state_r == Release) && !rst_ack_i) begin
            clr_grant_s = grant_r;
        end else begin
            clr_grant_s = SrcZero;
        end
    end

    pwrmgr_rst_prio_enc #(
        .Width (NumReqs + 1)
    ) u_prio_enc (
        .req (pending_r),
        .gnt (gnt_s)
    );

    // Sticky pending bits; a new set beats a same-cycle clear or drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r <= SrcZero;
        end else begin
            pending_r <= (pending_r & ~clr_grant_s & ~drop_s) | set_s;
        end
    end

    // Handshake sequencer with registered request/busy decode and cause record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= Idle;
            grant_r       <= SrcZero;
            cause_r       <= SrcZero;
            cause_valid_r <= 1'b0;
            rst_req_r     <= 1'b0;
            busy_r        <= 1'b0;
            cnt_r         <= 8'd0;
        end else begin
            case (state_r)
                Idle: begin
                    if (pending_r != SrcZero) begin
                        grant_r       <= gnt_s;
                        cause_r       <= gnt_s;
                        cause_valid_r <= 1'b1;
                        rst_req_r     <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ReqRst;
                    end else if (clr_i) begin
                        cause_r       <= SrcZero;
                        cause_valid_r <= 1'b0;
                    end
                end
                ReqRst: begin
                    if (rst_ack_i) begin
                        cnt_r   <= HoldLoad;
                        state_r <= Hold;
                    end
                end
                Hold: begin
                    if (cnt_r == 8'd0) begin
                        rst_req_r <= 1'b0;
                        state_r   <= Release;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                Release: begin
                    if (!rst_ack_i) begin
                        grant_r <= SrcZero;
                        busy_r  <= 1'b0;
                        state_r <= Idle;
                    end
                end
                default: begin
                    grant_r   <= SrcZero;
                    rst_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    cnt_r     <= 8'd0;
                    state_r   <= Idle;
                end
            endcase
        end
    end

    assign rst_req_o     = rst_req_r;
    assign pending_o     = pending_r;
    assign cause_o       = cause_r;
    assign cause_valid_o = cause_valid_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_pwrmgr_rst_arb.sv
// Directed self-checking bench for pwrmgr_rst_arb (NumReqs=2, HoldCycles=4).
module tb_pwrmgr_rst_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] en;
    logic       esc_req;
    logic       clr;
    logic       rst_req;
    logic       rst_ack;
    logic [2:0] pending;
    logic [2:0] cause;
    logic       cause_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pwrmgr_rst_arb #(
        .NumReqs    (2),
        .HoldCycles (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .en_i          (en),
        .esc_req_i     (esc_req),
        .clr_i         (clr),
        .rst_req_o     (rst_req),
        .rst_ack_i     (rst_ack),
        .pending_o     (pending),
        .cause_o       (cause),
        .cause_valid_o (cause_valid),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one full handshake: wait for the request, ack after ack_dly cycles,
    // count request-high cycles, drop ack while driving exit_req for one cycle.
    task automatic do_hs(input int ack_dly, input logic [1:0] exit_req,
                         output logic [2:0] cause_seen, output int low_cyc,
                         output int high_cyc);
        low_cyc = 0;
        while (rst_req !== 1'b1 && low_cyc < 20) begin
            step();
            low_cyc++;
        end
        check("hs_req_seen", rst_req, 1);
        cause_seen = cause;
        for (int i = 0; i < ack_dly; i++) step();
        rst_ack  = 1'b1;
        high_cyc = 0;
        while (rst_req === 1'b1 && high_cyc < 50) begin
            high_cyc++;
            step();
        end
        rst_ack = 1'b0;
        req     = exit_req;
        step();
        req = 2'b00;
        check("hs_back_idle", busy, 0);
    endtask

    logic [2:0] c;
    int lo;
    int hi;

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        en      = 2'b11;
        esc_req = 1'b0;
        clr     = 1'b0;
        rst_ack = 1'b0;
        step();
        step();
        check("rst_req_reset", rst_req, 0);
        check("pending_reset", pending, 0);
        check("cause_reset", cause, 0);
        check("valid_reset", cause_valid, 0);
        check("busy_reset", busy, 0);
        rst_n = 1'b1;
        step();

        // Ack in Idle is ignored.
        rst_ack = 1'b1;
        step();
        step();
        check("idle_ack_busy", busy, 0);
        check("idle_ack_req", rst_req, 0);
        rst_ack = 1'b0;
        step();

        // Single request: latency, cause, hold length, pending retire.
        req = 2'b01;
        step();
        req = 2'b00;
        check("single_pend_t1", pending, 3'b001);
        check("single_req_t1", rst_req, 0);
        step();
        check("single_req_t2", rst_req, 1);
        check("single_cause", cause, 3'b001);
        check("single_valid", cause_valid, 1);
        check("single_busy", busy, 1);
        do_hs(2, 2'b00, c, lo, hi);
        check("single_high_len", hi, 5);
        check("single_pend_done", pending, 0);
        check("single_cause_kept", cause, 3'b001);

        // Priority: escalation, then source 0, then source 1.
        req     = 2'b11;
        esc_req = 1'b1;
        step();
        req     = 2'b00;
        esc_req = 1'b0;
        check("prio_pend", pending, 3'b111);
        do_hs(0, 2'b00, c, lo, hi);
        check("prio_cause1", c, 3'b100);
        check("prio_pend_after1", pending, 3'b011);
        do_hs(0, 2'b00, c, lo, hi);
        check("prio_cause2", c, 3'b001);
        check("prio_gap2", (lo >= 1), 1);
        do_hs(0, 2'b00, c, lo, hi);
        check("prio_cause3", c, 3'b010);
        check("prio_gap3", (lo >= 1), 1);
        check("prio_pend_done", pending, 0);

        // Enable mask blocks a disabled source.
        en  = 2'b01;
        req = 2'b10;
        step();
        req = 2'b00;
        check("mask_pend", pending, 0);
        step();
        step();
        check("mask_no_req", rst_req, 0);
        check("mask_no_busy", busy, 0);

        // Queued source 0 dropped when disabled while escalation is serviced.
        en      = 2'b11;
        req     = 2'b01;
        esc_req = 1'b1;
        step();
        req     = 2'b00;
        esc_req = 1'b0;
        check("drop_pend_both", pending, 3'b101);
        step();
        check("drop_grant_esc", cause, 3'b100);
        en = 2'b10;
        step();
        check("drop_pend_cleared", pending, 3'b100);
        do_hs(0, 2'b00, c, lo, hi);
        step();
        step();
        check("drop_no_second", rst_req, 0);
        check("drop_pend_zero", pending, 0);
        en = 2'b11;

        // Escalation arriving in Hold does not preempt source 0.
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        check("late_req", rst_req, 1);
        rst_ack = 1'b1;
        hi = 1;
        step();
        hi = 2;
        esc_req = 1'b1;
        step();
        esc_req = 1'b0;
        check("late_pend", pending, 3'b101);
        while (rst_req === 1'b1 && hi < 50) begin
            hi++;
            step();
        end
        check("late_high_len", hi, 5);
        check("late_cause_kept", cause, 3'b001);
        rst_ack = 1'b0;
        step();
        check("late_pend_esc", pending, 3'b100);
        do_hs(0, 2'b00, c, lo, hi);
        check("late_esc_cause", c, 3'b100);

        // Clear in Idle with nothing pending.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_idle_valid", cause_valid, 0);
        check("clr_idle_cause", cause, 0);

        // Clear while busy is ignored.
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy_valid", cause_valid, 1);
        check("clr_busy_cause", cause, 3'b001);
        do_hs(0, 2'b00, c, lo, hi);

        // Clear on the grant cycle loses to the grant; re-request at exit.
        req = 2'b10;
        step();
        req = 2'b00;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_grant_valid", cause_valid, 1);
        check("clr_grant_cause", cause, 3'b010);
        do_hs(0, 2'b10, c, lo, hi);
        check("rereq_pend", pending, 3'b010);
        do_hs(0, 2'b00, c, lo, hi);
        check("rereq_cause", c, 3'b010);
        check("rereq_pend_done", pending, 0);

        // Asynchronous reset in Hold.
        req = 2'b01;
        step();
        req = 2'b00;
        step();
        rst_ack = 1'b1;
        req     = 2'b10;
        step();
        req = 2'b00;
        step();
        check("arst_pre_req", rst_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", rst_req, 0);
        check("arst_pend", pending, 0);
        check("arst_cause", cause, 0);
        check("arst_busy", busy, 0);
        rst_ack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("arst_after_req", rst_req, 0);
        check("arst_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
